// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the CPU program sequencer: instruction classes, ALU opcodes,
// sequencer states and an instruction classifier.
package cpu_seq_pkg;

  localparam logic [3:0] CLS_ALU  = 4'h0;
  localparam logic [3:0] CLS_JMP  = 4'h1;
  localparam logic [3:0] CLS_JZ   = 4'h2;
  localparam logic [3:0] CLS_JC   = 4'h3;
  localparam logic [3:0] CLS_JN   = 4'h4;
  localparam logic [3:0] CLS_JV   = 4'h5;
  localparam logic [3:0] CLS_NOP  = 4'h6;
  localparam logic [3:0] CLS_HALT = 4'hF;

  // ALU opcodes, same values the datapath's operations header defines
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_INC = 4'h8;
  localparam logic [3:0] OP_DEC = 4'h9;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_DISPATCH = 3'd3,
    ST_RETIRE   = 3'd4,
    ST_HALT     = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    KIND_ALU     = 2'd0,
    KIND_FLOW    = 2'd1,
    KIND_HALT    = 2'd2,
    KIND_ILLEGAL = 2'd3
  } instr_kind_e;

  // Jumps and NOP share one path: they only differ in the PC they produce.
  function automatic instr_kind_e classify(input logic [3:0] cls);
    instr_kind_e kind;
    case (cls)
      CLS_ALU:                                     kind = KIND_ALU;
      CLS_JMP, CLS_JZ, CLS_JC, CLS_JN, CLS_JV,
      CLS_NOP:                                     kind = KIND_FLOW;
      CLS_HALT:                                    kind = KIND_HALT;
      default:                                     kind = KIND_ILLEGAL;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/cpu_seq_ctrl_branch_eval.sv
// Combinational branch resolution: decides whether a control-flow class redirects the PC
// given the registered ALU flags.
module cpu_seq_branch_eval
  import cpu_seq_pkg::*;
(
  input  logic [3:0] cls_i,
  input  logic       z_i,
  input  logic       c_i,
  input  logic       n_i,
  input  logic       v_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (cls_i)
      CLS_JMP: taken_o = 1'b1;
      CLS_JZ:  taken_o = z_i;
      CLS_JC:  taken_o = c_i;
      CLS_JN:  taken_o = n_i;
      CLS_JV:  taken_o = v_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Program sequencer for the 8-bit CPU: fetch, decode, branch and ALU dispatch with
// run/step/halt/resume control. Define SEQ_BREAKPOINT_EN to add a single PC breakpoint.
module cpu_seq_ctrl
  import cpu_seq_pkg::*;
#(
  parameter int PC_W             = 4,
  parameter int DISPATCH_TIMEOUT = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            run_i,
  input  logic            step_i,
  input  logic            resume_i,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic [7:0]      imem_data_i,
  input  logic            z_i,
  input  logic            c_i,
  input  logic            n_i,
  input  logic            v_i,
  output logic            exec_enable_o,
  output logic [3:0]      operation_o,
  input  logic            pc_inc_i,
  output logic [PC_W-1:0] pc_o,
  output logic            halted_o,
  output logic            busy_o,
  output logic            err_o
`ifdef SEQ_BREAKPOINT_EN
  ,
  input  logic            bp_en_i,
  input  logic [PC_W-1:0] bp_addr_i,
  output logic            bp_hit_o
`endif
);

  localparam logic [3:0] TMO_LAST = 4'(DISPATCH_TIMEOUT - 1);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            step_mode_q, step_mode_d;
  logic            err_q, err_d;
  logic [3:0]      op_q, op_d;
  logic            exec_q, exec_d;
  logic [3:0]      tmo_q, tmo_d;
  logic            halted_q, busy_q;

  logic [3:0]      instr_cls;
  logic [3:0]      instr_arg;
  logic            taken;
  logic            continuing;
  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] jump_target;

  assign instr_cls   = imem_data_i[7:4];
  assign instr_arg   = imem_data_i[3:0];
  assign continuing  = run_i & ~step_mode_q;
  assign pc_plus1    = pc_q + PC_W'(1);
  assign jump_target = PC_W'(instr_arg);

  cpu_seq_branch_eval u_branch_eval (
    .cls_i   (instr_cls),
    .z_i     (z_i),
    .c_i     (c_i),
    .n_i     (n_i),
    .v_i     (v_i),
    .taken_o (taken)
  );

`ifdef SEQ_BREAKPOINT_EN
  logic bp_skip_q, bp_skip_d;
  logic bp_hit_q, bp_hit_d;
  logic bp_match;

  assign bp_match = bp_en_i && (pc_q == bp_addr_i) && !bp_skip_q;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    step_mode_d = step_mode_q;
    err_d       = err_q;
    op_d        = op_q;
    exec_d      = 1'b0;
    tmo_d       = tmo_q;
`ifdef SEQ_BREAKPOINT_EN
    bp_skip_d   = bp_skip_q;
    bp_hit_d    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (run_i || step_i) begin
          state_d     = ST_FETCH;
          step_mode_d = step_i & ~run_i;
        end
      end

      ST_FETCH: begin
        state_d = ST_DECODE;
`ifdef SEQ_BREAKPOINT_EN
        // The bypass granted by resume is spent on the first fetch, hit or not.
        bp_skip_d = 1'b0;
        if (bp_match) begin
          state_d  = ST_HALT;
          bp_hit_d = 1'b1;
        end
`endif
      end

      ST_DECODE: begin
        case (classify(instr_cls))
          KIND_ALU: begin
            state_d = ST_DISPATCH;
            pc_d    = pc_plus1;
            op_d    = instr_arg;
            exec_d  = 1'b1;
            tmo_d   = 4'd0;
          end
          KIND_FLOW: begin
            pc_d    = taken ? jump_target : pc_plus1;
            state_d = continuing ? ST_FETCH : ST_IDLE;
          end
          KIND_HALT: begin
            pc_d    = pc_plus1;
            state_d = ST_HALT;
          end
          default: begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end
        endcase
      end

      ST_DISPATCH: begin
        if (pc_inc_i) begin
          state_d = ST_RETIRE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          tmo_d  = tmo_q + 4'd1;
          exec_d = 1'b1;
        end
      end

      // exec_enable is low here, guaranteeing the gap the edge-triggered consumer needs.
      ST_RETIRE: begin
        state_d = continuing ? ST_FETCH : ST_IDLE;
      end

      ST_HALT: begin
        if (resume_i) begin
          state_d = ST_IDLE;
`ifdef SEQ_BREAKPOINT_EN
          bp_skip_d = 1'b1;
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      step_mode_q <= 1'b0;
      err_q       <= 1'b0;
      op_q        <= 4'd0;
      exec_q      <= 1'b0;
      tmo_q       <= 4'd0;
      halted_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SEQ_BREAKPOINT_EN
      bp_skip_q   <= 1'b0;
      bp_hit_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      step_mode_q <= step_mode_d;
      err_q       <= err_d;
      op_q        <= op_d;
      exec_q      <= exec_d;
      tmo_q       <= tmo_d;
      halted_q    <= (state_d == ST_HALT);
      busy_q      <= (state_d != ST_IDLE) && (state_d != ST_HALT);
`ifdef SEQ_BREAKPOINT_EN
      bp_skip_q   <= bp_skip_d;
      bp_hit_q    <= bp_hit_d;
`endif
    end
  end

  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign exec_enable_o = exec_q;
  assign operation_o   = op_q;
  assign halted_o      = halted_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;
`ifdef SEQ_BREAKPOINT_EN
  assign bp_hit_o      = bp_hit_q;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: an instruction-level reference interpreter predicts
// dispatches, cycle counts and final PC/error; directed tests pin the corner cases.
module tb_cpu_seq_ctrl;
  localparam int PC_W  = 4;
  localparam int DEPTH = 1 << PC_W;

  logic            clk = 1'b0;
  logic            rst_ni, run_i, step_i, resume_i;
  logic [PC_W-1:0] imem_addr_o;
  logic [7:0]      imem_data_i;
  logic            z_i, c_i, n_i, v_i;
  logic            exec_enable_o;
  logic [3:0]      operation_o;
  logic            pc_inc_i;
  logic [PC_W-1:0] pc_o;
  logic            halted_o, busy_o, err_o;
`ifdef SEQ_BREAKPOINT_EN
  logic            bp_en_i;
  logic [PC_W-1:0] bp_addr_i;
  logic            bp_hit_o;
`endif

  always #5 clk = ~clk;

  cpu_seq_ctrl #(.PC_W(PC_W), .DISPATCH_TIMEOUT(4)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .run_i         (run_i),
    .step_i        (step_i),
    .resume_i      (resume_i),
    .imem_addr_o   (imem_addr_o),
    .imem_data_i   (imem_data_i),
    .z_i           (z_i),
    .c_i           (c_i),
    .n_i           (n_i),
    .v_i           (v_i),
    .exec_enable_o (exec_enable_o),
    .operation_o   (operation_o),
    .pc_inc_i      (pc_inc_i),
    .pc_o          (pc_o),
    .halted_o      (halted_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
`ifdef SEQ_BREAKPOINT_EN
    ,
    .bp_en_i       (bp_en_i),
    .bp_addr_i     (bp_addr_i),
    .bp_hit_o      (bp_hit_o)
`endif
  );

  // Synchronous instruction ROM: data for the address seen at an edge is valid next cycle.
  logic [7:0] rom [DEPTH];
  always @(posedge clk) imem_data_i <= rom[imem_addr_o];

  // cpu_ctrl_fsm stand-in: acknowledges a dispatch in its first cycle when enabled.
  bit ack_en = 1'b1;
  always @(negedge clk) pc_inc_i = ack_en && exec_enable_o;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Compare process: every cycle, dispatch opcodes against the expected queue plus invariants.
  logic [3:0] exp_ops[$];
  int   disp_cnt = 0, en_cycles = 0, bp_hits = 0;
  logic prev_en = 1'b0;
  bit   mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (exec_enable_o) begin
        en_cycles++;
        chk("exec_implies_busy", busy_o, 1);
      end
      if (exec_enable_o && !prev_en) begin
        int remaining;
        disp_cnt++;
        remaining = exp_ops.size();
        chk("dispatch_expected", remaining > 0, 1);
        if (remaining > 0) chk("dispatch_op", operation_o, exp_ops.pop_front());
      end
      chk("busy_halt_exclusive", busy_o & halted_o, 0);
`ifdef SEQ_BREAKPOINT_EN
      if (bp_hit_o) bp_hits++;
`endif
    end
    prev_en = exec_enable_o;
  end

  // Reference interpreter: walks the program one instruction at a time from PC 0.
  logic [3:0] m_ops[$];
  int m_cycles, m_pc;
  bit m_err;

  task automatic model_run(input bit z, input bit c, input bit n, input bit v);
    int pc;
    int cls, arg;
    bit t;
    pc = 0;
    m_ops.delete();
    m_cycles = 0;
    m_err = 1'b0;
    for (int i = 0; i < 64; i++) begin
      cls = int'(rom[pc][7:4]);
      arg = int'(rom[pc][3:0]);
      if (cls == 0) begin
        m_ops.push_back(arg[3:0]);
        m_cycles += 4;
        pc = (pc + 1) % DEPTH;
      end else if (cls >= 1 && cls <= 6) begin
        t = (cls == 1) || (cls == 2 && z) || (cls == 3 && c) || (cls == 4 && n) || (cls == 5 && v);
        m_cycles += 2;
        pc = t ? arg : (pc + 1) % DEPTH;
      end else if (cls == 15) begin
        m_cycles += 2;
        pc = (pc + 1) % DEPTH;
        break;
      end else begin
        m_cycles += 2;
        m_err = 1'b1;
        break;
      end
    end
    m_pc = pc;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    run_i = 1'b0; step_i = 1'b0; resume_i = 1'b0;
    ack_en = 1'b1;
    {z_i, c_i, n_i, v_i} = 4'b0000;
`ifdef SEQ_BREAKPOINT_EN
    bp_en_i = 1'b0; bp_addr_i = '0;
`endif
    exp_ops.delete();
    disp_cnt = 0; en_cycles = 0; bp_hits = 0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'h60;
  endtask

  // Wait for halted_o; cyc is 0 at the first sample after the run-sampling edge.
  task automatic wait_halt(input int budget, output int cyc, output bit seen);
    seen = 1'b0;
    cyc = -1;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      cyc = k;
      seen = halted_o;
    end
  endtask

  task automatic wait_exec(input int budget, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      seen = exec_enable_o;
    end
  endtask

  task automatic step_once();
    step_i = 1'b1;
    @(negedge clk);
    step_i = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  int last_cyc;

  task automatic run_prog(input string name, input bit z, input bit c, input bit n,
                          input bit v, input bit check_pc);
    bit seen;
    model_run(z, c, n, v);
    exp_ops = m_ops;
    disp_cnt = 0; en_cycles = 0;
    {z_i, c_i, n_i, v_i} = {z, c, n, v};
    run_i = 1'b1;
    wait_halt(300, last_cyc, seen);
    chk({name, "_halt_seen"}, seen, 1);
    chk({name, "_cycles"}, last_cyc, m_cycles);
    if (check_pc) chk({name, "_pc"}, pc_o, m_pc);
    chk({name, "_err"}, err_o, m_err);
    chk({name, "_dispatches"}, disp_cnt, m_ops.size());
    chk({name, "_pending_ops"}, exp_ops.size(), 0);
    run_i = 1'b0;
    $display("prog %s: cycles=%0d pc=%0d err=%0d dispatches=%0d", name, last_cyc, pc_o, err_o,
             disp_cnt);
  endtask

  initial begin
    bit seen;
    int cyc;

    rst_ni = 1'b0;
    run_i = 1'b0; step_i = 1'b0; resume_i = 1'b0;
    {z_i, c_i, n_i, v_i} = 4'b0000;
`ifdef SEQ_BREAKPOINT_EN
    bp_en_i = 1'b0; bp_addr_i = '0;
`endif
    clear_rom();
    repeat (2) @(negedge clk);
    chk("rst_exec", exec_enable_o, 0);
    chk("rst_op", operation_o, 0);
    chk("rst_halted", halted_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_addr", imem_addr_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_err", err_o, 0);
    $display("reset: outputs sampled while held");
    mon_en = 1'b1;

    // ADD then HALT under run
    do_reset(); clear_rom();
    rom[0] = 8'h00; rom[1] = 8'hF0;
    run_prog("add_halt", 0, 0, 0, 0, 1);
    chk("add_halt_cycles_lit", last_cyc, 6);
    chk("add_halt_pc_lit", pc_o, 2);
    chk("add_halt_en_cycles_lit", en_cycles, 1);
    chk("add_halt_halted_lit", halted_o, 1);

    // Mixed branch program under two flag sets
    do_reset(); clear_rom();
    rom[0] = 8'h05; rom[1] = 8'h23; rom[2] = 8'h0A; rom[3] = 8'h38; rom[4] = 8'h0C;
    rom[5] = 8'h59; rom[6] = 8'h90; rom[7] = 8'h90; rom[8] = 8'h1B; rom[9] = 8'h47;
    rom[10] = 8'h60; rom[11] = 8'h02; rom[12] = 8'hF0;
    run_prog("branch_a", 1, 0, 0, 1, 1);
    chk("branch_a_cycles_lit", last_cyc, 24);
    do_reset();
    run_prog("branch_b", 0, 1, 1, 0, 1);
    chk("branch_b_cycles_lit", last_cyc, 20);
    chk("branch_b_pc_lit", pc_o, 13);

    // JZ taken / not taken, single-stepped
    do_reset(); clear_rom();
    rom[0] = 8'h25;
    z_i = 1'b1;
    step_once();
    chk("jz_taken_pc", pc_o, 5);
    chk("jz_taken_busy", busy_o, 0);
    do_reset();
    z_i = 1'b0;
    step_once();
    chk("jz_not_taken_pc", pc_o, 1);
    $display("jz: step done, pc=%0d", pc_o);

    // Step on an ALU instruction: one dispatch, then idle
    do_reset(); clear_rom();
    rom[0] = 8'h03;
    exp_ops.push_back(4'h3);
    step_once();
    chk("step_alu_dispatches", disp_cnt, 1);
    chk("step_alu_busy", busy_o, 0);
    chk("step_alu_halted", halted_o, 0);
    chk("step_alu_pc", pc_o, 1);
    $display("step alu: dispatches=%0d pc=%0d", disp_cnt, pc_o);

    // Dispatch timeout with no acknowledge, then resume keeps err
    do_reset(); clear_rom();
    rom[0] = 8'h01;
    ack_en = 1'b0;
    exp_ops.push_back(4'h1);
    run_i = 1'b1;
    wait_halt(40, cyc, seen);
    run_i = 1'b0;
    chk("tmo_halt_seen", seen, 1);
    chk("tmo_cycles", cyc, 6);
    chk("tmo_en_cycles", en_cycles, 4);
    chk("tmo_err", err_o, 1);
    resume_i = 1'b1;
    @(negedge clk);
    resume_i = 1'b0;
    @(negedge clk);
    chk("tmo_resume_halted", halted_o, 0);
    chk("tmo_resume_err", err_o, 1);
    chk("tmo_resume_busy", busy_o, 0);
    $display("timeout: err=%0d after resume", err_o);

    // run_i drops during DISPATCH: instruction completes, then idle
    do_reset(); clear_rom();
    rom[0] = 8'h01; rom[1] = 8'h02; rom[2] = 8'hF0;
    exp_ops.push_back(4'h1);
    run_i = 1'b1;
    wait_exec(20, seen);
    chk("runfall_exec_seen", seen, 1);
    run_i = 1'b0;
    repeat (6) @(negedge clk);
    chk("runfall_busy", busy_o, 0);
    chk("runfall_halted", halted_o, 0);
    chk("runfall_pc", pc_o, 1);
    chk("runfall_dispatches", disp_cnt, 1);
    $display("run fall: pc=%0d dispatches=%0d", pc_o, disp_cnt);

    // Resume and step together in HALT: resume wins, step dropped
    do_reset(); clear_rom();
    rom[0] = 8'hF0; rom[1] = 8'h60;
    run_prog("halt_only", 0, 0, 0, 0, 1);
    resume_i = 1'b1; step_i = 1'b1;
    @(negedge clk);
    resume_i = 1'b0; step_i = 1'b0;
    chk("resume_step_halted", halted_o, 0);
    chk("resume_step_busy_now", busy_o, 0);
    repeat (4) @(negedge clk);
    chk("resume_step_busy", busy_o, 0);
    chk("resume_step_pc", pc_o, 1);

    // Jump to the last address then wrap to 0
    do_reset(); clear_rom();
    rom[0] = 8'h1F; rom[15] = 8'h60;
    step_once();
    chk("wrap_jmp_pc", pc_o, 15);
    step_once();
    chk("wrap_next_pc", pc_o, 0);
    $display("wrap: pc=%0d", pc_o);

    // Illegal class
    do_reset(); clear_rom();
    rom[0] = 8'h90;
    run_prog("illegal", 0, 0, 0, 0, 0);
    chk("illegal_err_lit", err_o, 1);
    chk("illegal_halted_lit", halted_o, 1);

    // Asynchronous reset while dispatching
    do_reset(); clear_rom();
    rom[0] = 8'h04;
    ack_en = 1'b0;
    exp_ops.push_back(4'h4);
    run_i = 1'b1;
    wait_exec(20, seen);
    chk("areset_exec_seen", seen, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("areset_exec", exec_enable_o, 0);
    chk("areset_busy", busy_o, 0);
    chk("areset_pc", pc_o, 0);
    run_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    $display("async reset: exec=%0d", exec_enable_o);

`ifdef SEQ_BREAKPOINT_EN
    do_reset(); clear_rom();
    rom[3] = 8'h01; rom[4] = 8'hF0;
    bp_en_i = 1'b1; bp_addr_i = 4'd3;
    exp_ops.push_back(4'h1);
    run_i = 1'b1;
    wait_halt(40, cyc, seen);
    chk("bp_halt_seen", seen, 1);
    chk("bp_cycles", cyc, 7);
    chk("bp_pc", pc_o, 3);
    chk("bp_no_dispatch", disp_cnt, 0);
    repeat (2) @(negedge clk);
    chk("bp_hit_pulses", bp_hits, 1);
    resume_i = 1'b1;
    @(negedge clk);
    resume_i = 1'b0;
    wait_halt(40, cyc, seen);
    chk("bp_resume_halt_seen", seen, 1);
    chk("bp_resume_pc", pc_o, 5);
    chk("bp_resume_dispatch", disp_cnt, 1);
    chk("bp_resume_hits", bp_hits, 1);
    run_i = 1'b0;
    $display("breakpoint: pc=%0d hits=%0d", pc_o, bp_hits);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "bench time limit reached");
  end

endmodule
